regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Read-side companion to the core register file: walks a contiguous register range through one asynchronous read port.
- Streams each register out as little-endian bytes on a valid/ready byte interface.
- Intended consumers: UART or debug transmitter for post-run register dumps on the FPGA board.
- Owns no architectural state; observes the register file only.

Parameters:
- DataWidth, 32, register width in bits; must be a multiple of 8. BytesPerReg = DataWidth/8.
- AddrRegWidth, 5, register address width.
- FirstReg, 0, first register index dumped.
- LastReg, 31, last register index dumped; FirstReg <= LastReg < 2**AddrRegWidth.

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a dump; ignored while busy=1
- abort  input  1  cancels an in-progress dump
- rd_addr  output  AddrRegWidth  register-file read address (combinational read port)
- rd_data  input  DataWidth  register-file read data for rd_addr, same cycle
- tx_data  output  8  byte being offered
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both 1
- tx_last  output  1  qualifies the final byte of the dump (byte 0 of FirstReg is not special)
- busy  output  1  dump in progress (state != IDLE)
- done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset values (clock edge with reset=1):
  - state=IDLE, reg_idx=FirstReg, byte_cnt=0, shift=0.
  - tx_valid=0, tx_last=0, done=0, busy=0, tx_data=0.
  - rd_addr=FirstReg.
  - reset overrides start and abort, and takes effect mid-dump; tx_valid is 0 in the following cycle.
- rd_addr is always driven from the reg_idx register, never combinationally from inputs.
- IDLE:
  - start=1 -> LOAD; reg_idx=FirstReg.
- LOAD (one cycle):
  - shift <= rd_data (the snapshot for this register); byte_cnt <= 0 -> SEND.
  - Registers are not captured coherently across the dump; each value is the one read in its own LOAD cycle.
- SEND:
  - tx_valid=1, tx_data=shift[7:0].
  - tx_last=1 only when reg_idx==LastReg and byte_cnt==BytesPerReg-1.
  - tx_data and tx_last stay stable while tx_valid=1 and tx_ready=0.
  - On handshake with byte_cnt < BytesPerReg-1: shift >>= 8, byte_cnt++.
  - On handshake on the final byte of a register, reg_idx < LastReg: reg_idx++ -> LOAD.
  - On handshake on the final byte of a register, reg_idx == LastReg -> DONE.
- DONE (one cycle): done=1 -> IDLE; reg_idx <= FirstReg.
- Abort:
  - abort=1 in LOAD, SEND or DONE -> IDLE next cycle; reg_idx <= FirstReg; done not pulsed.
  - Abort is the only permitted withdrawal of tx_valid without a handshake.
  - A handshake in the same cycle as abort counts as accepted by the sink; the block still goes to IDLE.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- start while busy is ignored; it does not queue.
- Latency, with tx_ready held at 1:
  - start sampled at edge N -> LOAD in cycle N+1 -> first tx_valid in cycle N+2.
  - Each register takes 1 + BytesPerReg cycles.
  - The done pulse occurs (LastReg-FirstReg+1)*(1+BytesPerReg) + 1 cycles after start.
  - Default parameters: 161 cycles.
- No arithmetic beyond increments; reg_idx never wraps, because the range end is checked before incrementing.

Test Plan:
- Load register 2 = 0x00000200, register 7 = 0xDEADBEEF, all others 0; pulse start; tx_ready=1.
  - 128 bytes out; bytes 8..11 = 00 02 00 00; bytes 28..31 = EF BE AD DE.
  - tx_last only on byte 127; done exactly 161 cycles after start.
- FirstReg=LastReg=7 build; drive tx_ready in a 1-in-3 pattern.
  - tx_data held stable while stalled; bytes EF,BE,AD,DE; tx_last on DE; done 1 cycle after the last handshake.
- Pulse start again at byte 50 of a running dump.
  - Byte stream unchanged; total still 128 bytes; single done pulse.
- Assert abort in the same cycle as the handshake of byte 17.
  - Next cycle: tx_valid=0, busy=0, no done.
  - A new start restarts from register FirstReg, byte 0.
- Assert reset in SEND while stalled (tx_ready=0).
  - Next cycle all outputs at reset values; rd_addr=FirstReg.
- Write register 5 from 0x11111111 to 0x22222222 between its LOAD and its byte-2 handshake.
  - Emitted bytes are 11 11 11 11 (the snapshot is held).

Source files
------------

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range through an async read port
// and streams each register out as little-endian bytes on a valid/ready interface.
module regfile_dump_reader #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5,
  parameter int FirstReg     = 0,
  parameter int LastReg      = 31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [AddrRegWidth-1:0] rd_addr,
  input  logic [DataWidth-1:0]    rd_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic                    busy,
  output logic                    done
);

  localparam int BytesPerReg = DataWidth / 8;
  localparam int CntWidth    = (BytesPerReg > 1) ? $clog2(BytesPerReg) : 1;
  localparam logic [AddrRegWidth-1:0] FirstIdx = AddrRegWidth'(FirstReg);
  localparam logic [AddrRegWidth-1:0] LastIdx  = AddrRegWidth'(LastReg);
  localparam logic [CntWidth-1:0]     LastByte = CntWidth'(BytesPerReg - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [AddrRegWidth-1:0] reg_idx_q, reg_idx_d;
  logic [CntWidth-1:0]     byte_cnt_q, byte_cnt_d;
  logic [DataWidth-1:0]    shift_q, shift_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    tx_last_q, tx_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    handshake;
  logic                    last_byte;

  assign handshake = tx_valid_q && tx_ready;
  assign last_byte = (byte_cnt_q == LastByte);

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          reg_idx_d = FirstIdx;
        end
      end
      LOAD: begin
        shift_d    = rd_data;
        byte_cnt_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (!last_byte) begin
            shift_d    = shift_q >> 8;
            byte_cnt_d = byte_cnt_q + CntWidth'(1);
          end else if (reg_idx_q != LastIdx) begin
            reg_idx_d = reg_idx_q + AddrRegWidth'(1);
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        reg_idx_d = FirstIdx;
      end
      default: begin
        state_d   = IDLE;
        reg_idx_d = FirstIdx;
      end
    endcase

    // Abort drops tx_valid immediately; a same-cycle handshake is still counted by the sink.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      reg_idx_d = FirstIdx;
    end

    tx_valid_d = (state_d == SEND);
    tx_last_d  = (state_d == SEND) && (reg_idx_d == LastIdx) && (byte_cnt_d == LastByte);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      reg_idx_q  <= FirstIdx;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr  = reg_idx_q;
  assign tx_data  = shift_q[7:0];
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
